// File: rtl/edge_arb_pkg.sv
// Shared types for the edge event arbiter:
// detector and arbiter state codes.
package edge_arb_pkg;

  typedef enum logic [1:0] {
    DET_ZERO = 2'b00,
    DET_EDGE = 2'b10,
    DET_ONE  = 2'b11
  } det_state_e;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/edge_det_cell.sv
// Single-channel Moore rising-edge detector.
// edge_pulse_o is high for one cycle per rising edge.
module edge_det_cell
  import edge_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic edge_pulse_o
);

  det_state_e state_q, state_d;

  // Next state; the unused code 2'b01 recovers to ZERO
  always_comb begin
    state_d = DET_ZERO;
    unique case (state_q)
      DET_ZERO: state_d = level_i ? DET_EDGE : DET_ZERO;
      DET_EDGE: state_d = level_i ? DET_ONE : DET_ZERO;
      DET_ONE:  state_d = level_i ? DET_ONE : DET_ZERO;
      default:  state_d = DET_ZERO;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= DET_ZERO;
    else         state_q <= state_d;
  end

  assign edge_pulse_o = (state_q == DET_EDGE);

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel edge collector with pending/overrun
// flags and a round-robin valid/ready event offer.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int IDX_W = 2
) (
  input  logic             i_clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  level,
  input  logic [N_CH-1:0]  enable,
  input  logic             clr_overrun,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_chan,
  input  logic             evt_ready,
  output logic [N_CH-1:0]  pending,
  output logic [N_CH-1:0]  overrun
);

  localparam logic [IDX_W-1:0] LAST_RST =
    IDX_W'(N_CH - 1);

  logic [N_CH-1:0]  edge_pulse;
  logic [N_CH-1:0]  set_v;
  logic [N_CH-1:0]  clr_v;
  logic [N_CH-1:0]  pending_q, pending_d;
  logic [N_CH-1:0]  overrun_q, overrun_d;
  arb_state_e       arb_q;
  logic             evt_valid_q;
  logic [IDX_W-1:0] evt_chan_q;
  logic [IDX_W-1:0] last_grant_q;
  logic             accept;

  // First requester strictly after last, wrapping
  // modulo N_CH (not 2^IDX_W).
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [N_CH-1:0]  req,
    input logic [IDX_W-1:0] last
  );
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic             found;
    int               c;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      c   = (int'(last) + k) % N_CH;
      idx = IDX_W'(c);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign accept = evt_valid_q & evt_ready;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    edge_det_cell u_det (
      .clk_i        (i_clk),
      .rst_ni       (rst_n),
      .level_i      (level[g]),
      .edge_pulse_o (edge_pulse[g])
    );
    assign set_v[g] = edge_pulse[g] & enable[g];
    assign clr_v[g] = accept &
                      (evt_chan_q == IDX_W'(g));
  end

  // A new edge landing on the grant cycle is a fresh
  // event, not an overrun; an overrun set beats the clear.
  always_comb begin
    pending_d = (pending_q & ~clr_v) | set_v;
    overrun_d = clr_overrun ? '0 : overrun_q;
    overrun_d = overrun_d |
                (set_v & pending_q & ~clr_v);
  end

  // Pending and overrun flag registers
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Arbiter: pick in IDLE, hold the offer until ready
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_q        <= ARB_IDLE;
      evt_valid_q  <= 1'b0;
      evt_chan_q   <= '0;
      last_grant_q <= LAST_RST;
    end else begin
      unique case (arb_q)
        ARB_IDLE: begin
          if (|pending_q) begin
            evt_chan_q  <= rr_pick(pending_q,
                                   last_grant_q);
            evt_valid_q <= 1'b1;
            arb_q       <= ARB_OFFER;
          end
        end
        ARB_OFFER: begin
          if (evt_ready) begin
            last_grant_q <= evt_chan_q;
            evt_valid_q  <= 1'b0;
            arb_q        <= ARB_IDLE;
          end
        end
      endcase
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_chan  = evt_chan_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule
